// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write port of the loader.
// slave  = loader side (consumes bytes, drives the write port)
// master = environment side (drives bytes, observes writes)
interface imem_loader_if;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;

   modport slave (
      input  byte_in, byte_valid,
      output byte_ready, wr_en, wr_addr, wr_data
   );

   modport master (
      output byte_in, byte_valid,
      input  byte_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: packs an MSB-first byte stream into 32-bit instruction words,
// writes them to instruction memory and holds the CPU fetch stage meanwhile.
// Build macro IMEM_LOADER_CHECKSUM_EN enables the running XOR checksum;
// without it the checksum port is tied to zero.
module imem_loader #(
   parameter int unsigned DEPTH     = 16,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [4:0]   num_words,
   input  logic         abort,
   imem_loader_if.slave bus,
   output logic         cpu_hold,
   output logic         busy,
   output logic         done,
   output logic [4:0]   words_loaded,
   output logic [31:0]  checksum
);
   // Word count is 5 bits wide, so the usable depth saturates at 31 words.
   localparam int unsigned WORD_CAP = (DEPTH > 31) ? 31 : DEPTH;

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_e;

   state_e      state_q, state_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [23:0] shift_q, shift_d;
   logic [4:0]  n_q, n_d;
   logic [4:0]  words_q, words_d;
   logic        wr_en_q, wr_en_d;
   logic [31:0] wr_addr_q, wr_addr_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic        busy_q, busy_d;
   logic        hold_q, hold_d;
   logic        done_q, done_d;
   logic [31:0] word_c;

   // Next-state, byte packing and write-port computation.
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      n_d        = n_q;
      words_d    = words_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      word_c     = {shift_q, bus.byte_in};

      unique case (state_q)
         IDLE: begin
            if (start) begin
               n_d        = (num_words > 5'(WORD_CAP)) ? 5'(WORD_CAP) : num_words;
               byte_cnt_d = 2'd0;
               words_d    = 5'd0;
               state_d    = (n_d == 5'd0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            // Abort wins over a byte offered in the same cycle; partial word dropped.
            if (abort) begin
               state_d    = IDLE;
               byte_cnt_d = 2'd0;
            end else if (bus.byte_valid) begin
               byte_cnt_d = byte_cnt_q + 2'd1;
               shift_d    = {shift_q[15:0], bus.byte_in};
               if (byte_cnt_q == 2'd3) begin
                  wr_en_d   = 1'b1;
                  wr_data_d = word_c;
                  wr_addr_d = BASE_ADDR + (32'(words_q) << 2);
                  words_d   = words_q + 5'd1;
                  if (words_d == n_q) begin
                     state_d = FLUSH;
                  end
               end
            end
         end
         FLUSH:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
      hold_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State and registered-output flops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         byte_cnt_q <= 2'd0;
         shift_q    <= 24'd0;
         n_q        <= 5'd0;
         words_q    <= 5'd0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= 32'd0;
         wr_data_q  <= 32'd0;
         busy_q     <= 1'b0;
         hold_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
         n_q        <= n_d;
         words_q    <= words_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         busy_q     <= busy_d;
         hold_q     <= hold_d;
         done_q     <= done_d;
      end
   end

   assign bus.byte_ready = (state_q == LOAD);
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign busy           = busy_q;
   assign cpu_hold       = hold_q;
   assign done           = done_q;
   assign words_loaded   = words_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic        load_start_c;
   logic [31:0] checksum_q, checksum_d;

   assign load_start_c = (state_q == IDLE) && start;

   // Running XOR of every word written; cleared only by an accepted start.
   always_comb begin
      checksum_d = checksum_q;
      if (load_start_c) begin
         checksum_d = 32'd0;
      end else if (wr_en_d) begin
         checksum_d = checksum_q ^ wr_data_d;
      end
   end

   // Checksum register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         checksum_q <= 32'd0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign checksum = checksum_q;
`else
   assign checksum = 32'd0;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table vectors, hand sequences and randomized loads checked
// against a byte-stream reference model of the loader.
module tb_imem_loader;
   localparam int          DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h0;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  num_words = 5'd0;
   logic        abort = 1'b0;
   logic        cpu_hold, busy, done;
   logic [4:0]  words_loaded;
   logic [31:0] checksum;

   imem_loader_if bus();

   imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .num_words    (num_words),
      .abort        (abort),
      .bus          (bus),
      .cpu_hold     (cpu_hold),
      .busy         (busy),
      .done         (done),
      .words_loaded (words_loaded),
      .checksum     (checksum)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] cyc;
   } wr_t;

   typedef struct {
      logic [4:0]  nw;
      int          gap;
      int          abort_at;
      bit          abort_late;
      int          exp_wr;
      int          exp_done;
      logic [4:0]  exp_wl;
      logic [31:0] exp_last;
   } vec_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] cyc_g   = 32'd0;
   int          done_cnt = 0;
   wr_t         wq[$];
   wr_t         exp_q[$];
   logic [7:0]  stim_b [0:127];
   vec_t        vecs [10];

   always @(posedge clk) cyc_g <= cyc_g + 32'd1;

   // Write and done-pulse monitor.
   always @(negedge clk) begin
      if (bus.wr_en) wq.push_back('{bus.wr_addr, bus.wr_data, cyc_g});
      if (done) done_cnt++;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < 128; i++) stim_b[i] = 8'($urandom);
   endtask

   // Drives one load and checks it cycle by cycle against the stream model.
   task automatic run_load(input logic [4:0] nw, input int gap_mode, input int abort_at,
                           input bit abort_late, input bit start_noise, input string tag,
                           output int n_wr, output logic [31:0] last_addr);
      int          n, acc, fin, cyc, end_t, k;
      bit          ab, idle, exp_ready, exp_done, want;
      logic [31:0] xs, d;
      exp_q.delete();
      wq.delete();
      done_cnt = 0;
      n     = (int'(nw) > DEPTH) ? DEPTH : int'(nw);
      end_t = (n == 0) ? 1 : 2;
      repeat (2) begin
         @(negedge clk);
         bus.byte_valid = 1'b1;
         bus.byte_in    = 8'($urandom);
         abort          = 1'($urandom);
      end
      @(negedge clk);
      bus.byte_valid = 1'b0;
      abort          = 1'b0;
      start          = 1'b1;
      num_words      = nw;
      acc = 0; fin = 0; cyc = 0; ab = 1'b0; idle = 1'b0; xs = 32'd0;
      while (!idle && cyc < 400) begin
         @(negedge clk);
         start          = 1'b0;
         abort          = 1'b0;
         bus.byte_valid = 1'b0;
         bus.byte_in    = 8'($urandom);
         cyc++;
         if (acc == 4 * n && !ab) fin++;
         idle      = ab || (fin > end_t);
         exp_ready = !ab && (acc < 4 * n);
         exp_done  = !ab && (fin == end_t);
         check({tag, " byte_ready"}, 64'(bus.byte_ready), 64'(exp_ready));
         check({tag, " busy"}, 64'(busy), 64'(!idle));
         check({tag, " cpu_hold"}, 64'(cpu_hold), 64'(!idle));
         check({tag, " done"}, 64'(done), 64'(exp_done));
         if (!idle) begin
            case (gap_mode)
               0:       want = 1'b1;
               1:       want = (cyc % 2 == 1);
               default: want = ($urandom % 3 != 0);
            endcase
            if (exp_ready && abort_at == acc) begin
               abort = 1'b1;
               ab    = 1'b1;
            end else if (exp_ready && want) begin
               bus.byte_valid = 1'b1;
               bus.byte_in    = stim_b[acc];
               if (acc % 4 == 3) begin
                  k  = acc / 4;
                  d  = {stim_b[acc-3], stim_b[acc-2], stim_b[acc-1], stim_b[acc]};
                  xs = xs ^ d;
                  exp_q.push_back('{BASE + 32'(4 * k), d, cyc_g + 32'd1});
               end
               acc++;
            end else if (!exp_ready && abort_late) begin
               abort = 1'b1;
            end
            if (start_noise && ($urandom % 3 == 0)) begin
               start     = 1'b1;
               num_words = 5'($urandom);
            end
         end
      end
      start = 1'b0; abort = 1'b0; bus.byte_valid = 1'b0;
      check({tag, " reached idle"}, 64'(idle), 64'd1);
      check({tag, " write count"}, 64'(wq.size()), 64'(exp_q.size()));
      for (int i = 0; i < wq.size() && i < exp_q.size(); i++) begin
         check($sformatf("%s wr_addr[%0d]", tag, i), 64'(wq[i].addr), 64'(exp_q[i].addr));
         check($sformatf("%s wr_data[%0d]", tag, i), 64'(wq[i].data), 64'(exp_q[i].data));
         check($sformatf("%s wr_cycle[%0d]", tag, i), 64'(wq[i].cyc), 64'(exp_q[i].cyc));
      end
      check({tag, " words_loaded"}, 64'(words_loaded), 64'(exp_q.size()));
`ifdef IMEM_LOADER_CHECKSUM_EN
      check({tag, " checksum"}, 64'(checksum), 64'(xs));
`else
      check({tag, " checksum"}, 64'(checksum), 64'(32'd0 & xs));
`endif
      n_wr      = wq.size();
      last_addr = (wq.size() > 0) ? wq[wq.size()-1].addr : 32'hFFFF_FFFF;
   endtask

   initial begin
      int          n_wr;
      logic [31:0] la;
      logic [31:0] exp_sum;

      vecs[0] = '{5'd2,  0, -1, 1'b0,  2, 1, 5'd2,  32'd4};
      vecs[1] = '{5'd1,  1, -1, 1'b0,  1, 1, 5'd1,  32'd0};
      vecs[2] = '{5'd0,  0, -1, 1'b0,  0, 1, 5'd0,  32'd0};
      vecs[3] = '{5'd20, 0, -1, 1'b0, 16, 1, 5'd16, 32'd60};
      vecs[4] = '{5'd3,  0,  6, 1'b0,  1, 0, 5'd1,  32'd0};
      vecs[5] = '{5'd31, 1, -1, 1'b0, 16, 1, 5'd16, 32'd60};
      vecs[6] = '{5'd4,  2,  8, 1'b0,  2, 0, 5'd2,  32'd4};
      vecs[7] = '{5'd5,  0,  0, 1'b0,  0, 0, 5'd0,  32'd0};
      vecs[8] = '{5'd2,  0, -1, 1'b1,  2, 1, 5'd2,  32'd4};
      vecs[9] = '{5'd16, 2, -1, 1'b1, 16, 1, 5'd16, 32'd60};

      bus.byte_in = 8'd0;
      bus.byte_valid = 1'b0;

      // Reset state.
      repeat (3) @(negedge clk);
      check("reset busy", 64'(busy), 64'd0);
      check("reset cpu_hold", 64'(cpu_hold), 64'd0);
      check("reset wr_en", 64'(bus.wr_en), 64'd0);
      check("reset wr_addr", 64'(bus.wr_addr), 64'd0);
      check("reset words_loaded", 64'(words_loaded), 64'd0);
      check("reset byte_ready", 64'(bus.byte_ready), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      // Table vectors.
      for (int v = 0; v < 10; v++) begin
         fill_random();
         run_load(vecs[v].nw, vecs[v].gap, vecs[v].abort_at, vecs[v].abort_late, 1'b0,
                  $sformatf("vec%0d", v), n_wr, la);
         check($sformatf("vec%0d n_writes", v), 64'(n_wr), 64'(vecs[v].exp_wr));
         check($sformatf("vec%0d done_pulses", v), 64'(done_cnt), 64'(vecs[v].exp_done));
         check($sformatf("vec%0d words_loaded", v), 64'(words_loaded), 64'(vecs[v].exp_wl));
         if (vecs[v].exp_wr > 0)
            check($sformatf("vec%0d last_addr", v), 64'(la), 64'(vecs[v].exp_last));
      end

      // Known byte stream with known words.
      stim_b[0] = 8'h90; stim_b[1] = 8'h00; stim_b[2] = 8'h48; stim_b[3] = 8'h89;
      stim_b[4] = 8'h90; stim_b[5] = 8'h00; stim_b[6] = 8'h50; stim_b[7] = 8'h89;
      run_load(5'd2, 0, -1, 1'b0, 1'b0, "known", n_wr, la);
      check("known n_writes", 64'(n_wr), 64'd2);
      if (wq.size() >= 2) begin
         check("known word0", 64'(wq[0].data), 64'h9000_4889);
         check("known addr0", 64'(wq[0].addr), 64'd0);
         check("known word1", 64'(wq[1].data), 64'h9000_5089);
         check("known addr1", 64'(wq[1].addr), 64'd4);
      end

      // Checksum of two complementary words, then hold after completion.
      stim_b[0] = 8'h00; stim_b[1] = 8'h00; stim_b[2] = 8'h00; stim_b[3] = 8'h0F;
      stim_b[4] = 8'h00; stim_b[5] = 8'h00; stim_b[6] = 8'h00; stim_b[7] = 8'hF0;
      run_load(5'd2, 0, -1, 1'b0, 1'b0, "csum", n_wr, la);
`ifdef IMEM_LOADER_CHECKSUM_EN
      exp_sum = 32'h0000_00FF;
`else
      exp_sum = 32'h0;
`endif
      check("csum value", 64'(checksum), 64'(exp_sum));
      repeat (3) @(negedge clk);
      check("csum hold", 64'(checksum), 64'(exp_sum));

      // Reset mid-load after two bytes.
      fill_random();
      run_load(5'd3, 0, -1, 1'b0, 1'b0, "pre_rst", n_wr, la);
      @(negedge clk);
      start = 1'b1; num_words = 5'd3;
      @(negedge clk);
      start = 1'b0;
      bus.byte_valid = 1'b1; bus.byte_in = 8'hA5;
      @(negedge clk);
      bus.byte_in = 8'h5A;
      @(negedge clk);
      bus.byte_valid = 1'b0;
      check("pre-reset busy", 64'(busy), 64'd1);
      #2 rst = 1'b0;
      #1;
      check("mid-reset busy", 64'(busy), 64'd0);
      check("mid-reset cpu_hold", 64'(cpu_hold), 64'd0);
      check("mid-reset done", 64'(done), 64'd0);
      check("mid-reset wr_en", 64'(bus.wr_en), 64'd0);
      check("mid-reset wr_addr", 64'(bus.wr_addr), 64'd0);
      check("mid-reset wr_data", 64'(bus.wr_data), 64'd0);
      check("mid-reset words_loaded", 64'(words_loaded), 64'd0);
      check("mid-reset checksum", 64'(checksum), 64'd0);
      check("mid-reset byte_ready", 64'(bus.byte_ready), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      wq.delete();
      repeat (8) begin
         @(negedge clk);
         bus.byte_valid = 1'b1;
         bus.byte_in = 8'($urandom);
      end
      @(negedge clk);
      bus.byte_valid = 1'b0;
      check("post-reset writes", 64'(wq.size()), 64'd0);
      check("post-reset busy", 64'(busy), 64'd0);

      // Randomized loads with gaps, aborts and ignored start pulses.
      for (int r = 0; r < 30; r++) begin
         int nw, n, ab_at;
         nw    = $urandom_range(0, 22);
         n     = (nw > DEPTH) ? DEPTH : nw;
         ab_at = -1;
         if (n > 0 && ($urandom % 4 == 0)) ab_at = $urandom_range(0, 4 * n - 1);
         fill_random();
         run_load(5'(nw), $urandom_range(0, 2), ab_at, 1'($urandom), 1'b1,
                  $sformatf("rnd%0d", r), n_wr, la);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
